// File: rtl/mcu_spi_reg_slave.sv
// SPI mode-0 target for the MCU link: decodes fixed command+data frames into
// single-cycle register-bus read/write strobes in the clk domain.
module mcu_spi_reg_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso_o,
    output logic                  spi_miso_t,
    output logic [6:0]            reg_addr,
    output logic                  reg_wr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  frame_abort
);
    localparam int FRAME_BITS = 8 + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, RDATA, WDATA, DONE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, sync_vld;
    logic                   sck_d, cs_d, armed;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   wait_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift, tx_shift;
    logic [7:0]             cmd_byte;
    logic                   rd_nxt, wr_nxt, abort_nxt;

    // sync_vld marks when cs_s reflects the pin rather than its reset value, so a
    // frame already running when reset releases cannot fake a CS_N falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sync_vld  <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            if (sync_vld[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign cs_rise    = cs_s & ~cs_d;
    assign cs_fall    = ~cs_s & cs_d & armed;
    assign sck_rise   = sck_s & ~sck_d & ~cs_s;
    assign sck_fall   = ~sck_s & sck_d & ~cs_s;
    assign spi_miso_t = cs_s;
    assign cmd_byte   = {rx_shift[6:0], mosi_s};

    // SCK edges are masked while CS_N is high, so a coincident CS_N rise wins.
    always_comb begin
        state_nxt = state;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sck_rise && bit_cnt == CMD_LAST) begin
                    if (cmd_byte[7]) begin
                        state_nxt = RD_WAIT;
                        rd_nxt    = 1'b1;
                    end else begin
                        state_nxt = WDATA;
                    end
                end
            end
            RD_WAIT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (wait_cnt) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sck_rise && bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end
            end
            WDATA: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (sck_rise && bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                    wr_nxt    = 1'b1;
                end
            end
            DONE: if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            wait_cnt    <= 1'b0;
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            frame_abort <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            spi_miso_o  <= 1'b0;
        end else begin
            state       <= state_nxt;
            reg_rd      <= rd_nxt;
            reg_wr      <= wr_nxt;
            frame_abort <= abort_nxt;
            wait_cnt    <= (state == RD_WAIT);
            if (state == IDLE)
                bit_cnt <= '0;
            else if (sck_rise && state != DONE)
                bit_cnt <= bit_cnt + CNT_W'(1);
            if (state == CMD && sck_rise && bit_cnt == CMD_LAST)
                reg_addr <= cmd_byte[6:0];
            if (wr_nxt)
                reg_wdata <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            if (state != RDATA)
                spi_miso_o <= 1'b0;
            else if (sck_fall)
                spi_miso_o <= tx_shift[DATA_WIDTH-1];
        end
    end

    // Shift registers carry data only; they are cleared at frame start instead of by reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && cs_fall)
            rx_shift <= '0;
        else if (sck_rise)
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        if (state == RD_WAIT && wait_cnt)
            tx_shift <= reg_rdata;
        else if (state == RDATA && sck_fall)
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
    end

endmodule

// File: tb/tb_mcu_spi_reg_slave.sv
// Directed bench for mcu_spi_reg_slave: an MCU-side SPI master model plus a
// register-file model that returns read data exactly two clocks after reg_rd.
module tb_mcu_spi_reg_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck, spi_cs_n, spi_mosi;
    logic        spi_miso_o, spi_miso_t;
    logic [6:0]  reg_addr;
    logic        reg_wr, reg_rd, frame_abort;
    logic [15:0] reg_wdata, reg_rdata;

    int n_cmp = 0;
    int n_fail = 0;
    int half = 6;
    int wr_cnt = 0, rd_cnt = 0, ab_cnt = 0, tri_bad = 0;
    logic [6:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        rd_fixed = 1'b1;

    always #5 clk = ~clk;

    mcu_spi_reg_slave #(.SYNC_STAGES(2), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .frame_abort(frame_abort)
    );

    // Register file: read data valid only in the cycle sampled two clocks after reg_rd.
    always @(posedge clk)
        reg_rdata <= reg_rd ? (rd_fixed ? 16'h1234 : {1'b0, reg_addr, ~{1'b0, reg_addr}})
                            : 16'hDEAD;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt++;
            rd_addr = reg_addr;
        end
        if (frame_abort) ab_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input int n, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            clks(half);
            spi_sck = 1'b1;
            rx = {rx[30:0], spi_miso_o};
            if (spi_miso_t !== 1'b0) tri_bad++;
            clks(half);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] tx, output logic [31:0] rx);
        spi_cs_n = 1'b0;
        clks(half);
        spi_bits(n, tx, rx);
        clks(half);
        spi_cs_n = 1'b1;
        clks(8);
    endtask

    task automatic test_reset();
        clks(3);
        n_cmp++; if (reg_wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", reg_wr); end
        n_cmp++; if (reg_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got %b want 0", reg_rd); end
        n_cmp++; if (frame_abort !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got %b want 0", frame_abort); end
        n_cmp++; if (reg_addr !== 7'h00) begin n_fail++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
        n_cmp++; if (reg_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_wdata: got %h want 0000", reg_wdata); end
        n_cmp++; if (spi_miso_o !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b want 0", spi_miso_o); end
        n_cmp++; if (spi_miso_t !== 1'b1) begin n_fail++; $display("FAIL rst_miso_t: got %b want 1", spi_miso_t); end
        rst = 1'b0;
        clks(6);
        n_cmp++; if (spi_miso_t !== 1'b1) begin n_fail++; $display("FAIL idle_miso_t: got %b want 1", spi_miso_t); end
    endtask

    task automatic test_write();
        int w0, r0, a0;
        logic [31:0] rx;
        w0 = wr_cnt; r0 = rd_cnt; a0 = ab_cnt;
        frame(24, {8'h05, 16'hA5C3}, rx);
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_addr !== 7'h05) begin n_fail++; $display("FAIL wr_addr: got %h want 05", wr_addr); end
        n_cmp++; if (wr_data !== 16'hA5C3) begin n_fail++; $display("FAIL wr_data: got %h want a5c3", wr_data); end
        n_cmp++; if (rd_cnt - r0 !== 0) begin n_fail++; $display("FAIL wr_no_rd: got %0d want 0", rd_cnt - r0); end
        n_cmp++; if (ab_cnt - a0 !== 0) begin n_fail++; $display("FAIL wr_no_abort: got %0d want 0", ab_cnt - a0); end
        n_cmp++; if (rx !== 32'h0) begin n_fail++; $display("FAIL wr_miso_zero: got %h want 0", rx); end
    endtask

    task automatic test_read();
        int w0, r0, a0, t0;
        logic [31:0] rx;
        rd_fixed = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt; a0 = ab_cnt; t0 = tri_bad;
        frame(24, {8'h85, 16'h0000}, rx);
        n_cmp++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL rd_count: got %0d want 1", rd_cnt - r0); end
        n_cmp++; if (rd_addr !== 7'h05) begin n_fail++; $display("FAIL rd_addr: got %h want 05", rd_addr); end
        n_cmp++; if (rx[15:0] !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h want 1234", rx[15:0]); end
        n_cmp++; if (rx[23:16] !== 8'h00) begin n_fail++; $display("FAIL rd_cmd_miso: got %h want 00", rx[23:16]); end
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL rd_no_wr: got %0d want 0", wr_cnt - w0); end
        n_cmp++; if (ab_cnt - a0 !== 0) begin n_fail++; $display("FAIL rd_no_abort: got %0d want 0", ab_cnt - a0); end
        n_cmp++; if (tri_bad - t0 !== 0) begin n_fail++; $display("FAIL rd_miso_t_low: got %0d high samples want 0", tri_bad - t0); end
        n_cmp++; if (spi_miso_t !== 1'b1) begin n_fail++; $display("FAIL rd_miso_t_after: got %b want 1", spi_miso_t); end
    endtask

    task automatic test_abort();
        int w0, a0;
        logic [31:0] rx;
        w0 = wr_cnt; a0 = ab_cnt;
        frame(12, {8'h10, 4'hA}, rx);
        n_cmp++; if (ab_cnt - a0 !== 1) begin n_fail++; $display("FAIL abort_count: got %0d want 1", ab_cnt - a0); end
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL abort_no_wr: got %0d want 0", wr_cnt - w0); end
        frame(24, {8'h11, 16'hFFFF}, rx);
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL post_abort_wr: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_addr !== 7'h11) begin n_fail++; $display("FAIL post_abort_addr: got %h want 11", wr_addr); end
        n_cmp++; if (wr_data !== 16'hFFFF) begin n_fail++; $display("FAIL post_abort_data: got %h want ffff", wr_data); end
        n_cmp++; if (ab_cnt - a0 !== 1) begin n_fail++; $display("FAIL post_abort_abort: got %0d want 1", ab_cnt - a0); end
    endtask

    task automatic test_overlong();
        int w0, a0;
        logic [31:0] rx;
        w0 = wr_cnt; a0 = ab_cnt;
        frame(32, {8'h02, 16'h0001, 8'hFF}, rx);
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL long_wr_count: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_addr !== 7'h02) begin n_fail++; $display("FAIL long_addr: got %h want 02", wr_addr); end
        n_cmp++; if (wr_data !== 16'h0001) begin n_fail++; $display("FAIL long_data: got %h want 0001", wr_data); end
        n_cmp++; if (rx !== 32'h0) begin n_fail++; $display("FAIL long_miso_zero: got %h want 0", rx); end
        n_cmp++; if (ab_cnt - a0 !== 0) begin n_fail++; $display("FAIL long_no_abort: got %0d want 0", ab_cnt - a0); end
    endtask

    task automatic test_reset_midframe();
        int w0, a0;
        logic [31:0] rx;
        w0 = wr_cnt; a0 = ab_cnt;
        spi_cs_n = 1'b0;
        clks(half);
        spi_bits(10, 32'({8'h07, 2'b10}), rx);
        rst = 1'b1;
        #1;
        n_cmp++; if (reg_addr !== 7'h00) begin n_fail++; $display("FAIL mid_rst_addr: got %h want 00", reg_addr); end
        n_cmp++; if (reg_wdata !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_wdata: got %h want 0000", reg_wdata); end
        n_cmp++; if (spi_miso_t !== 1'b1) begin n_fail++; $display("FAIL mid_rst_miso_t: got %b want 1", spi_miso_t); end
        n_cmp++; if ({reg_wr, reg_rd, frame_abort, spi_miso_o} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_rst_strobes: got %b want 0000", {reg_wr, reg_rd, frame_abort, spi_miso_o});
        end
        clks(2);
        rst = 1'b0;
        spi_bits(14, 32'h3BEF, rx);
        clks(half);
        spi_cs_n = 1'b1;
        clks(8);
        n_cmp++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL mid_no_wr: got %0d want 0", wr_cnt - w0); end
        n_cmp++; if (ab_cnt - a0 !== 0) begin n_fail++; $display("FAIL mid_no_abort: got %0d want 0", ab_cnt - a0); end
        frame(24, {8'h08, 16'h1357}, rx);
        n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL mid_next_wr: got %0d want 1", wr_cnt - w0); end
        n_cmp++; if (wr_addr !== 7'h08) begin n_fail++; $display("FAIL mid_next_addr: got %h want 08", wr_addr); end
        n_cmp++; if (wr_data !== 16'h1357) begin n_fail++; $display("FAIL mid_next_data: got %h want 1357", wr_data); end
    endtask

    task automatic test_back_to_back();
        int r0;
        logic [31:0] rx;
        logic [7:0]  a8;
        logic [15:0] exp;
        rd_fixed = 1'b0;
        half = 4;
        r0 = rd_cnt;
        for (int a = 0; a < 128; a++) begin
            a8 = 8'(a);
            exp = {a8, ~a8};
            frame(24, {1'b1, a8[6:0], 16'h0000}, rx);
            n_cmp++;
            if (rx[15:0] !== exp) begin
                n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", a, rx[15:0], exp);
            end
        end
        n_cmp++; if (rd_cnt - r0 !== 128) begin n_fail++; $display("FAIL b2b_rd_count: got %0d want 128", rd_cnt - r0); end
    endtask

    initial begin
        rst = 1'b1;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_overlong();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
